// File: rtl/square_root_adder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package    : squcsa_pkg                                                |
// | Description: Shared width and carry-select group plan for the 9-bit    |
// |              square-root carry-select adder.                           |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
package squcsa_pkg;

    localparam int WIDTH  = 9;

    // Group sizes grow toward the MSB so local sums settle before the select carry.
    localparam int G0_LSB = 0;
    localparam int G0_W   = 2;
    localparam int G1_LSB = 2;
    localparam int G1_W   = 3;
    localparam int G2_LSB = 5;
    localparam int G2_W   = 4;

    typedef logic [WIDTH-1:0] operand_t;

endpackage
`default_nettype wire

// File: rtl/square_root_adder_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface  : square_root_adder_if                                      |
// | Description: Operand/result bundle for square_root_adder.              |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
interface square_root_adder_if;
    import squcsa_pkg::*;

    operand_t a;
    operand_t b;
    logic     c_in;
    logic     in_valid;
    operand_t sum;
    logic     c_out;
    logic     out_valid;

    modport master (
        output a, b, c_in, in_valid,
        input  sum, c_out, out_valid
    );

    modport slave (
        input  a, b, c_in, in_valid,
        output sum, c_out, out_valid
    );

endinterface
`default_nettype wire

// File: rtl/square_root_adder_csa_block.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : csa_block                                                 |
// | Description: W-bit carry-select group: two ripple adders (cin 0/1)     |
// |              and a sum/carry mux driven by the select carry.           |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module csa_block #(
    parameter int W = 4
) (
    input  wire logic [W-1:0] x,
    input  wire logic [W-1:0] y,
    input  wire logic         cin_sel,
    output logic      [W-1:0] s,
    output logic              cout
);

    logic [W:0]   w_c0;
    logic [W:0]   w_c1;
    logic [W-1:0] w_s0;
    logic [W-1:0] w_s1;

    assign w_c0[0] = 1'b0;
    assign w_c1[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_ripple
            assign w_s0[gi]   = x[gi] ^ y[gi] ^ w_c0[gi];
            assign w_c0[gi+1] = (x[gi] & y[gi]) | (w_c0[gi] & (x[gi] ^ y[gi]));
            assign w_s1[gi]   = x[gi] ^ y[gi] ^ w_c1[gi];
            assign w_c1[gi+1] = (x[gi] & y[gi]) | (w_c1[gi] & (x[gi] ^ y[gi]));
        end
    endgenerate

    assign s    = cin_sel ? w_s1    : w_s0;
    assign cout = cin_sel ? w_c1[W] : w_c0[W];

endmodule
`default_nettype wire

// File: rtl/square_root_adder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : square_root_adder                                         |
// | Description: Registered 9-bit square-root carry-select adder (2/3/4    |
// |              bit groups). Define SQUCSA_INPUT_REG_EN to add an input   |
// |              register stage (latency 2 instead of 1).                  |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module square_root_adder
    import squcsa_pkg::*;
(
    input wire logic          clk,
    input wire logic          rst_n,
    square_root_adder_if.slave bus
);

    operand_t w_a;
    operand_t w_b;
    logic     w_cin;
    logic     w_vld;

`ifdef SQUCSA_INPUT_REG_EN
    operand_t a_q,   a_d;
    operand_t b_q,   b_d;
    logic     cin_q, cin_d;
    logic     vld_q, vld_d;

    always_comb begin
        a_d   = bus.a;
        b_d   = bus.b;
        cin_d = bus.c_in;
        vld_d = bus.in_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cin_q <= cin_d;
            vld_q <= vld_d;
        end
    end

    assign w_a   = a_q;
    assign w_b   = b_q;
    assign w_cin = cin_q;
    assign w_vld = vld_q;
`else
    assign w_a   = bus.a;
    assign w_b   = bus.b;
    assign w_cin = bus.c_in;
    assign w_vld = bus.in_valid;
`endif

    // G0: plain ripple seeded by c_in; its carry selects G1.
    logic [G0_W:0]   w_g0_c;
    logic [G0_W-1:0] w_s0;

    assign w_g0_c[0] = w_cin;

    generate
        for (genvar gi = 0; gi < G0_W; gi++) begin : g_g0_ripple
            assign w_s0[gi]     = w_a[G0_LSB+gi] ^ w_b[G0_LSB+gi] ^ w_g0_c[gi];
            assign w_g0_c[gi+1] = (w_a[G0_LSB+gi] & w_b[G0_LSB+gi])
                                | (w_g0_c[gi] & (w_a[G0_LSB+gi] ^ w_b[G0_LSB+gi]));
        end
    endgenerate

    logic [G1_W-1:0] w_s1;
    logic            w_c1;
    logic [G2_W-1:0] w_s2;
    logic            w_c2;

    csa_block #(.W(G1_W)) u_g1 (
        .x       (w_a[G1_LSB +: G1_W]),
        .y       (w_b[G1_LSB +: G1_W]),
        .cin_sel (w_g0_c[G0_W]),
        .s       (w_s1),
        .cout    (w_c1)
    );

    csa_block #(.W(G2_W)) u_g2 (
        .x       (w_a[G2_LSB +: G2_W]),
        .y       (w_b[G2_LSB +: G2_W]),
        .cin_sel (w_c1),
        .s       (w_s2),
        .cout    (w_c2)
    );

    operand_t sum_q,       sum_d;
    logic     c_out_q,     c_out_d;
    logic     out_valid_q, out_valid_d;

    always_comb begin
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        out_valid_d = w_vld;
        if (w_vld) begin
            sum_d   = {w_s2, w_s1, w_s0};
            c_out_d = w_c2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_square_root_adder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : tb_square_root_adder                                      |
// | Description: Self-checking bench: directed corners plus random vectors |
// |              against an arithmetic a+b+c_in pipeline model.            |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module tb_square_root_adder;

`ifdef SQUCSA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;

    square_root_adder_if bus_if ();

    square_root_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: queue of {valid, 10-bit result} entries still in flight.
    logic [10:0] pend[$];
    logic [8:0]  exp_sum;
    logic        exp_cout;
    logic        exp_ov;

    task automatic model_reset();
        pend.delete();
        for (int i = 0; i < LAT - 1; i++) pend.push_back(11'd0);
        exp_sum  = '0;
        exp_cout = 1'b0;
        exp_ov   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    endtask

    // One clock: apply inputs, advance the model, check all outputs.
    task automatic cyc(input logic rn, input logic [8:0] a, input logic [8:0] b,
                       input logic ci, input logic v);
        logic [9:0]  total;
        logic [10:0] head;
        rst_n          = rn;
        bus_if.a       = a;
        bus_if.b       = b;
        bus_if.c_in    = ci;
        bus_if.in_valid = v;
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
            total = 10'(a) + 10'(b) + 10'(ci);
            pend.push_back({v, total});
            head   = pend.pop_front();
            exp_ov = head[10];
            if (head[10]) begin
                exp_sum  = head[8:0];
                exp_cout = head[9];
            end
        end
        #1;
        check("sum",       {1'b0, bus_if.sum},       {1'b0, exp_sum});
        check("c_out",     {9'd0, bus_if.c_out},     {9'd0, exp_cout});
        check("out_valid", {9'd0, bus_if.out_valid}, {9'd0, exp_ov});
    endtask

    logic [8:0] corners [6];

    initial begin
        corners[0] = 9'd0;   corners[1] = 9'd1;   corners[2] = 9'd255;
        corners[3] = 9'd256; corners[4] = 9'd510; corners[5] = 9'd511;
        model_reset();

        // Reset state
        cyc(1'b0, 9'd0, 9'd0, 1'b0, 1'b0);
        cyc(1'b0, 9'd0, 9'd0, 1'b0, 1'b0);

        // 0+0+1, full carry ripple, group-select boundaries
        cyc(1'b1, 9'd0,   9'd0, 1'b1, 1'b1);
        cyc(1'b1, 9'd511, 9'd0, 1'b1, 1'b1);
        cyc(1'b1, 9'd3,   9'd0, 1'b1, 1'b1);
        cyc(1'b1, 9'd31,  9'd1, 1'b0, 1'b1);
        for (int i = 0; i < LAT; i++) cyc(1'b1, 9'd0, 9'd0, 1'b0, 1'b0);

        // Valid gating: result must hold while in_valid is low
        cyc(1'b1, 9'h1FF, 9'h1FF, 1'b1, 1'b1);
        cyc(1'b1, 9'd17,  9'd42,  1'b0, 1'b0);
        cyc(1'b1, 9'd99,  9'd7,   1'b1, 1'b0);
        cyc(1'b1, 9'd5,   9'd6,   1'b0, 1'b0);

        // Reset beats a simultaneous valid and discards in-flight data
        cyc(1'b1, 9'd10,  9'd20,  1'b0, 1'b1);
        cyc(1'b0, 9'd100, 9'd200, 1'b0, 1'b1);
        cyc(1'b1, 9'd1,   9'd2,   1'b1, 1'b1);
        cyc(1'b1, 9'd0,   9'd0,   1'b0, 1'b0);
        cyc(1'b1, 9'd0,   9'd0,   1'b0, 1'b0);

        // Corner operand pairs with both carry-in values
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                for (int k = 0; k < 2; k++)
                    cyc(1'b1, corners[i], corners[j], k[0], 1'b1);

        // Random back-to-back vectors
        for (int n = 0; n < 10000; n++)
            cyc(1'b1, 9'($urandom), 9'($urandom), 1'($urandom), 1'b1);

        // Random with gaps in in_valid and occasional reset
        for (int n = 0; n < 600; n++)
            cyc(($urandom_range(0, 49) != 0), 9'($urandom), 9'($urandom),
                1'($urandom), 1'($urandom));

        for (int i = 0; i < LAT; i++) cyc(1'b1, 9'd0, 9'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/square_root_adder.md
# square_root_adder

Registered 9-bit square-root carry-select adder (SQUCSA): computes `{c_out, sum} = a + b + c_in` in fixed-size carry-select groups of 2, 3 and 4 bits. Group sizes grow toward the MSB so each group's local sums settle before its select carry arrives. It is the arithmetic datapath leaf of the adder-comparison project and feeds downstream logic through a registered result with a valid strobe.

## Interface
- `WIDTH`, 9, operand/sum width; fixed, not overridable (group plan depends on it).
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `a`  input  9  operand A, unsigned.
- `b`  input  9  operand B, unsigned.
- `c_in`  input  1  carry into bit 0.
- `in_valid`  input  1  operands valid this cycle.
- `sum`  output  9  registered sum bits [8:0].
- `c_out`  output  1  registered carry out of bit 8.
- `out_valid`  output  1  `sum`/`c_out` hold a fresh result.

## Operation
- Groups: G0 = bits [1:0] (plain ripple, carry in = `c_in`); G1 = bits [4:2]; G2 = bits [8:5].
- G1 and G2 each compute two ripple sums in parallel: one assuming carry-in 0, one assuming carry-in 1 (each with its own group carry-out).
- Select carry for G1 = G0 carry-out; select carry for G2 = G1 selected carry-out.
- Per group: mux picks sum bits and carry-out by the select carry; `c_out` = G2 selected carry-out.
- Result must equal the 10-bit unsigned value `a + b + c_in` for all 2^19 input combinations; no saturation, wrap at 2^9 with carry reported in `c_out`.
- `sum`, `c_out` registers load only when `in_valid` = 1; otherwise hold previous value.
- `out_valid` register loads `in_valid` every cycle.

## Timing
- Latency 1 cycle: operands sampled at edge N with `in_valid` = 1 appear on `sum`/`c_out` with `out_valid` = 1 after edge N.
- Throughput one result per cycle; back-to-back `in_valid` allowed, no stall/backpressure.
- Reset (`rst_n` = 0 at a rising edge): `sum` = 0, `c_out` = 0, `out_valid` = 0; reset wins over simultaneous `in_valid`.
- Reset asserted mid-stream: the in-flight result is discarded; first valid result appears one cycle after the first post-reset edge with `in_valid` = 1.
- Combinational path a/b/c_in → register is bounded by G0 ripple + two mux stages + G2 4-bit ripple (parallel); no combinational input-to-output path.

## Configuration
- `SQUCSA_INPUT_REG_EN` defined: `a`, `b`, `c_in`, `in_valid` captured in an input register stage (reset to 0) before the adder; latency becomes 2 cycles, throughput unchanged, output register behaviour identical.
- Not defined: operands feed the adder directly; latency 1 cycle.

## Structure
- Shared package `squcsa_pkg`: `WIDTH` = 9, group boundary constants (G0_LSB=0/G0_W=2, G1_LSB=2/G1_W=3, G2_LSB=5/G2_W=4), `typedef logic [WIDTH-1:0] operand_t`.
- One sub-module: `csa_block` — parameterized width W, inputs x, y, cin_sel; internally two W-bit ripple adders (cin 0 and 1) plus sum/carry muxes; outputs s[W-1:0], cout. G0 is a `csa_block`-free ripple (or `csa_block` with both halves tied to `c_in`).
- Top instantiates G0 ripple, two `csa_block`s, output/valid registers, optional input registers.

## Test plan
- Reset then `a`=0, `b`=0, `c_in`=1, `in_valid`=1 → next cycle `sum`=1, `c_out`=0, `out_valid`=1.
- `a`=511, `b`=0, `c_in`=1 → `sum`=0, `c_out`=1 (full carry ripple through all three groups).
- `a`=3, `b`=0, `c_in`=1 → `sum`=4 (G0→G1 select); `a`=31, `b`=1, `c_in`=0 → `sum`=32 (G1→G2 select), `c_out`=0.
- Valid gating: result 0x1FF+0x1FF+1 (`sum`=511, `c_out`=1), then `in_valid`=0 with new operands → outputs hold 511/1, `out_valid`=0.
- Assert `rst_n`=0 together with `in_valid`=1, `a`=100, `b`=200 → after edge `sum`=0, `c_out`=0, `out_valid`=0.
- 10k random back-to-back vectors plus all c_in/boundary corners → every output matches `a+b+c_in` with correct latency (1, or 2 with `SQUCSA_INPUT_REG_EN`).
